fp32_addsub_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision add/subtract unit with a valid/ready handshake on both sides. It is the responder that neuron-update initiators (membrane-potential accumulate and leak) issue operand requests to. It returns one result per accepted request. It complements the combinational Addition_Subtraction unit where the timing budget cannot absorb a single-cycle adder.

---
 rtl/fp32_pkg.sv | 40 ++++
 rtl/fp32_unpack.sv | 20 ++
 rtl/fp32_addsub_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_fp32_addsub_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared field widths, IEEE-754 constants, FSM encoding and a leading-zero
// counter for the multi-cycle single-precision add/subtract unit.
package fp32_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    // Hidden bit + fraction + guard/round/sticky
    localparam int EXT_W   = MAN_W + 4;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADD    = 3'd3,
        S_NORM   = 3'd4,
        S_PACK   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    function automatic logic [4:0] lzc_ext(input logic [EXT_W-1:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = EXT_W - 1; i >= 0; i--) begin
            if (!found && !v[i]) begin
                n = n + 5'd1;
            end else begin
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Splits one IEEE-754 single into sign, exponent and mantissa with hidden bit,
// and flags zero/denormal exponents and Inf/NaN exponents.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]      op,
    output logic             sign,
    output logic [EXP_W-1:0] expo,
    output logic [MAN_W:0]   man,
    output logic             is_zero,
    output logic             is_special
);

    assign sign       = op[31];
    assign expo       = op[30:23];
    assign is_zero    = (expo == {EXP_W{1'b0}});
    assign is_special = (expo == EXP_W'(EXP_MAX));
    assign man        = {~is_zero, op[MAN_W-1:0]};

endmodule

// File: rtl/fp32_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract with valid/ready on both sides.
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp32_addsub_seq #(
    parameter int NORM_STEP = 1,
    parameter int BIAS      = fp32_pkg::BIAS
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception
);
    import fp32_pkg::*;

    localparam int XW = EXT_W;
    localparam logic signed [9:0] EXP_INF = 10'(2 * BIAS + 1);
    localparam logic [4:0] STEP = (NORM_STEP == 2 || NORM_STEP == 4 || NORM_STEP == 8) ?
                                  5'(NORM_STEP) : 5'd1;
    localparam logic [XW-1:0] GRS_CLR = {{(XW-3){1'b1}}, 3'b000};

    state_t              state_r;
    logic [31:0]         a_r, b_r;
    logic                sub_r;
    logic                sa_r, sb_r, special_r;
    logic [EXP_W-1:0]    ea_r, eb_r;
    logic [MAN_W:0]      ma_r, mb_r;
    logic                sign_r, eff_sub_r, zero_r;
    logic signed [9:0]   exp_r;
    logic [XW-1:0]       mx_r, my_r, mant_r;
    logic                in_ready_r, out_valid_r, exc_r;
    logic [31:0]         result_r;

    logic                a_sign_s, b_sign_s, a_zero_s, b_zero_s, a_special_s, b_special_s;
    logic [EXP_W-1:0]    a_exp_s, b_exp_s;
    logic [MAN_W:0]      a_man_s, b_man_s;

    fp32_unpack u_unpack_a (
        .op         (a_r),
        .sign       (a_sign_s),
        .expo       (a_exp_s),
        .man        (a_man_s),
        .is_zero    (a_zero_s),
        .is_special (a_special_s)
    );

    fp32_unpack u_unpack_b (
        .op         (b_r),
        .sign       (b_sign_s),
        .expo       (b_exp_s),
        .man        (b_man_s),
        .is_zero    (b_zero_s),
        .is_special (b_special_s)
    );

    logic                a_ge_s, big_sign_s;
    logic [EXP_W-1:0]    big_e_s, small_e_s, diff_s;
    logic [MAN_W:0]      big_m_s, small_m_s;
    logic [XW-1:0]       small_ext_s, al_small_s;
`ifdef FP_ROUND_NEAREST_EN
    logic [4:0]          shamt_s;
    logic [XW-1:0]       shifted_s, lost_s;
`endif

    // Alignment: order operands by magnitude and shift the smaller one right.
    always_comb begin
        a_ge_s      = ({ea_r, ma_r} >= {eb_r, mb_r});
        big_sign_s  = a_ge_s ? sa_r : sb_r;
        big_e_s     = a_ge_s ? ea_r : eb_r;
        small_e_s   = a_ge_s ? eb_r : ea_r;
        big_m_s     = a_ge_s ? ma_r : mb_r;
        small_m_s   = a_ge_s ? mb_r : ma_r;
        diff_s      = big_e_s - small_e_s;
        small_ext_s = {small_m_s, 3'b000};
`ifdef FP_ROUND_NEAREST_EN
        shamt_s     = (diff_s > 8'd27) ? 5'd27 : diff_s[4:0];
        shifted_s   = small_ext_s >> shamt_s;
        lost_s      = small_ext_s & ~({XW{1'b1}} << shamt_s);
        al_small_s  = {shifted_s[XW-1:1], shifted_s[0] | (|lost_s)};
`else
        if (diff_s >= 8'd25) begin
            al_small_s = {XW{1'b0}};
        end else begin
            al_small_s = (small_ext_s >> diff_s[4:0]) & GRS_CLR;
        end
`endif
    end

    logic [XW:0]         sum_s;
    logic [XW-1:0]       add_mant_s;
    logic signed [9:0]   add_exp_s;
    logic                add_zero_s, add_norm_s;

    // Magnitude add/subtract with a one-bit renormalisation on carry-out.
    always_comb begin
        if (eff_sub_r) begin
            sum_s = {1'b0, mx_r} - {1'b0, my_r};
        end else begin
            sum_s = {1'b0, mx_r} + {1'b0, my_r};
        end
        if (sum_s[XW]) begin
            add_mant_s = {sum_s[XW:2], sum_s[1] | sum_s[0]};
            add_exp_s  = exp_r + 10'sd1;
        end else begin
            add_mant_s = sum_s[XW-1:0];
            add_exp_s  = exp_r;
        end
        add_zero_s = (sum_s == {(XW+1){1'b0}});
        add_norm_s = !add_zero_s && !add_mant_s[XW-1] && (add_exp_s > 10'sd1);
    end

    logic [4:0]          lz_s, sh_s;
    logic [XW-1:0]       norm_mant_s;
    logic signed [9:0]   norm_exp_s;
    logic                norm_done_s;

    // One normalisation step; the exit decision looks at the post-shift value.
    always_comb begin
        lz_s        = lzc_ext(mant_r);
        sh_s        = (lz_s < STEP) ? lz_s : STEP;
        norm_mant_s = mant_r << sh_s;
        norm_exp_s  = exp_r - $signed({5'b00000, sh_s});
        norm_done_s = norm_mant_s[XW-1] || (norm_exp_s <= 10'sd1);
    end

    logic [31:0]         pack_result_s;
    logic                pack_exc_s;
`ifdef FP_ROUND_NEAREST_EN
    logic                round_up_s;
    logic [MAN_W+1:0]    rnd_s;
    logic signed [9:0]   rnd_exp_s;
    logic [MAN_W-1:0]    rnd_frac_s;
`endif

    // Result assembly; specials take priority, then overflow, then underflow.
    always_comb begin
        pack_result_s = 32'h0000_0000;
        pack_exc_s    = 1'b0;
`ifdef FP_ROUND_NEAREST_EN
        round_up_s    = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
        rnd_s         = {1'b0, mant_r[XW-1:3]} + {{(MAN_W+1){1'b0}}, round_up_s};
        if (rnd_s[MAN_W+1]) begin
            rnd_exp_s  = exp_r + 10'sd1;
            rnd_frac_s = rnd_s[MAN_W:1];
        end else begin
            rnd_exp_s  = exp_r;
            rnd_frac_s = rnd_s[MAN_W-1:0];
        end
`endif
        if (special_r) begin
            pack_result_s = QNAN;
            pack_exc_s    = 1'b1;
        end else if (zero_r) begin
            pack_result_s = 32'h0000_0000;
            pack_exc_s    = 1'b0;
        end else if (exp_r >= EXP_INF) begin
            pack_result_s = POS_INF | {sign_r, 31'h0000_0000};
            pack_exc_s    = 1'b1;
        end else if ((exp_r < 10'sd1) || !mant_r[XW-1]) begin
            pack_result_s = 32'h0000_0000;
            pack_exc_s    = 1'b0;
        end else begin
`ifdef FP_ROUND_NEAREST_EN
            if (rnd_exp_s >= EXP_INF) begin
                pack_result_s = POS_INF | {sign_r, 31'h0000_0000};
                pack_exc_s    = 1'b1;
            end else begin
                pack_result_s = {sign_r, rnd_exp_s[7:0], rnd_frac_s};
                pack_exc_s    = 1'b0;
            end
`else
            pack_result_s = {sign_r, exp_r[7:0], mant_r[XW-2:3]};
            pack_exc_s    = 1'b0;
`endif
        end
    end

    // Control FSM and all datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= 32'h0000_0000;
            exc_r       <= 1'b0;
            a_r         <= 32'h0000_0000;
            b_r         <= 32'h0000_0000;
            sub_r       <= 1'b0;
            sa_r        <= 1'b0;
            sb_r        <= 1'b0;
            special_r   <= 1'b0;
            ea_r        <= {EXP_W{1'b0}};
            eb_r        <= {EXP_W{1'b0}};
            ma_r        <= {(MAN_W+1){1'b0}};
            mb_r        <= {(MAN_W+1){1'b0}};
            sign_r      <= 1'b0;
            eff_sub_r   <= 1'b0;
            zero_r      <= 1'b0;
            exp_r       <= 10'sd0;
            mx_r        <= {XW{1'b0}};
            my_r        <= {XW{1'b0}};
            mant_r      <= {XW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a_operand;
                        b_r        <= b_operand;
                        sub_r      <= AddBar_Sub;
                        in_ready_r <= 1'b0;
                        state_r    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sa_r      <= a_sign_s;
                    sb_r      <= b_sign_s ^ sub_r;
                    ea_r      <= a_exp_s;
                    eb_r      <= b_exp_s;
                    // Denormals become true zeros here
                    ma_r      <= a_zero_s ? {(MAN_W+1){1'b0}} : a_man_s;
                    mb_r      <= b_zero_s ? {(MAN_W+1){1'b0}} : b_man_s;
                    special_r <= a_special_s | b_special_s;
                    state_r   <= (a_special_s | b_special_s) ? S_PACK : S_ALIGN;
                end
                S_ALIGN: begin
                    sign_r    <= big_sign_s;
                    eff_sub_r <= sa_r ^ sb_r;
                    exp_r     <= $signed({2'b00, big_e_s});
                    mx_r      <= {big_m_s, 3'b000};
                    my_r      <= al_small_s;
                    state_r   <= S_ADD;
                end
                S_ADD: begin
                    mant_r  <= add_mant_s;
                    exp_r   <= add_exp_s;
                    zero_r  <= add_zero_s;
                    state_r <= add_norm_s ? S_NORM : S_PACK;
                end
                S_NORM: begin
                    mant_r <= norm_mant_s;
                    exp_r  <= norm_exp_s;
                    if (norm_done_s) begin
                        state_r <= S_PACK;
                    end
                end
                S_PACK: begin
                    result_r    <= pack_result_s;
                    exc_r       <= pack_exc_s;
                    out_valid_r <= 1'b1;
                    state_r     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign Exception = exc_r;

endmodule

// File: tb/tb_fp32_addsub_seq.sv
// Directed bench for fp32_addsub_seq: scoreboard of expected results, latency,
// backpressure stability and mid-operation reset.
module tb_fp32_addsub_seq;

    logic        CLK;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        AddBar_Sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        Exception;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    fp32_addsub_seq #(.NORM_STEP(1), .BIAS(127)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_operand  (a_operand),
        .b_operand  (b_operand),
        .AddBar_Sub (AddBar_Sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .Exception  (Exception)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [31:0] res, input logic exc,
                           input int lat, input int hold);
        int   n;
        exp_t e;
        check({tag, ":in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        a_operand  = a;
        b_operand  = b;
        AddBar_Sub = sub;
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
        a_operand  = 32'hFFFF_FFFF;
        b_operand  = 32'hFFFF_FFFF;
        AddBar_Sub = ~sub;
        sb_q.push_back('{res, exc});
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, ":out_valid"}, {31'd0, out_valid}, 32'd1);
        if (lat >= 0) check({tag, ":latency"}, n, lat);
        e = sb_q.pop_front();
        check({tag, ":result"}, result, e.res);
        check({tag, ":exception"}, {31'd0, Exception}, {31'd0, e.exc});
        check({tag, ":in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, ":hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ":hold_result"}, result, e.res);
            check({tag, ":hold_exc"}, {31'd0, Exception}, {31'd0, e.exc});
            check({tag, ":hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ":valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, ":in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        RESET      = 1'b1;
        in_valid   = 1'b0;
        a_operand  = 32'd0;
        b_operand  = 32'd0;
        AddBar_Sub = 1'b0;
        out_ready  = 1'b0;
        step();
        step();
        check("rst:in_ready", {31'd0, in_ready}, 32'd1);
        check("rst:out_valid", {31'd0, out_valid}, 32'd0);
        check("rst:result", result, 32'd0);
        check("rst:exception", {31'd0, Exception}, 32'd0);
        RESET = 1'b0;
        step();

        run_req("5p5",      32'h40A0_0000, 32'h40A0_0000, 1'b0, 32'h4120_0000, 1'b0, 4, 2);
        run_req("5m5",      32'h40A0_0000, 32'h40A0_0000, 1'b1, 32'h0000_0000, 1'b0, 4, 0);
        run_req("1pm0p5",   32'h3F80_0000, 32'hBF00_0000, 1'b0, 32'h3F00_0000, 1'b0, 5, 0);
        run_req("inf_in",   32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1, -1, 0);
        run_req("ovf",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 4, 0);
        run_req("bp_1p1",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 4, 10);
        run_req("diff23",   32'h3F80_0000, 32'h3400_0000, 1'b0, 32'h3F80_0001, 1'b0, 4, 0);
        run_req("diff24",   32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 4, 0);
        run_req("zero_p3",  32'h0000_0000, 32'h4040_0000, 1'b0, 32'h4040_0000, 1'b0, 4, 0);
        run_req("denorm",   32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 4, 0);
        run_req("m2p1",     32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, 1'b0, 5, 0);
        run_req("1m2",      32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 1'b0, 5, 0);
        run_req("m5p5",     32'hC0A0_0000, 32'h40A0_0000, 1'b0, 32'h0000_0000, 1'b0, 4, 0);
        run_req("underflow",32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 1'b0, 4, 0);
        run_req("norm23",   32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3400_0000, 1'b0, 27, 0);

        // Reset while the long normalisation is in progress
        check("rst_mid:in_ready_idle", {31'd0, in_ready}, 32'd1);
        a_operand  = 32'h3F80_0000;
        b_operand  = 32'h3F7F_FFFF;
        AddBar_Sub = 1'b1;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        RESET = 1'b1;
        step();
        check("rst_mid:out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid:in_ready", {31'd0, in_ready}, 32'd1);
        RESET = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        check("rst_mid:no_output", seen, 32'd0);
        run_req("after_rst", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 4, 0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
